// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder cell sequenced LSB-first over WIDTH cycles.
// Optional subtract mode is enabled by defining SERIAL_ADD_SUB_EN.
module serial_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] psum_q, psum_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] b_in;
    logic             cin_in;
    logic             cell_s;
    logic             cell_c;

`ifdef SERIAL_ADD_SUB_EN
    // Two's-complement subtract: a + ~b + 1, so cin is overridden.
    assign b_in   = sub ? ~b : b;
    assign cin_in = sub | cin;
`else
    logic unused_sub;
    assign unused_sub = sub;
    assign b_in       = b;
    assign cin_in     = cin;
`endif

    assign cell_s = a_q[0] ^ b_q[0] ^ carry_q;
    assign cell_c = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            psum_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            psum_q  <= psum_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        psum_d  = psum_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b_in;
                    carry_d = cin_in;
                    psum_d  = '0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                psum_d  = {cell_s, psum_q[WIDTH-1:1]};
                carry_d = cell_c;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    // carry_q here is the carry into the MSB
                    sum_d   = {cell_s, psum_q[WIDTH-1:1]};
                    cout_d  = cell_c;
                    ovf_d   = carry_q ^ cell_c;
                    cnt_d   = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter: WIDTH, 16, operand/result width in bits, legal range 2..32.
REQ-002 Port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: start  input  1  request to begin an operation, sampled in IDLE only.
REQ-005 Port: a  input  WIDTH  operand A, captured on start acceptance.
REQ-006 Port: b  input  WIDTH  operand B, captured on start acceptance.
REQ-007 Port: cin  input  1  carry-in, captured on start acceptance.
REQ-008 Port: sub  input  1  subtract select, captured on start acceptance (see REQ-027/028).
REQ-009 Port: busy  output  1  high while in RUN.
REQ-010 Port: done  output  1  one-cycle pulse, result valid.
REQ-011 Port: sum  output  WIDTH  result, held until next result is written.
REQ-012 Port: cout  output  1  carry out of MSB, held with sum.
REQ-013 Port: ovf  output  1  signed overflow, held with sum.

Function
REQ-014 Block SHALL sequence one 1-bit full-adder cell (a, b, carry-in -> sum bit, carry-out) LSB-first over WIDTH cycles; no WIDTH-wide adder.
REQ-015 FSM states SHALL be IDLE, RUN, DONE; encoding free.
REQ-016 IDLE: start=1 at a rising edge -> capture a, b, cin, sub into shift/carry regs, bit counter := 0, go RUN.
REQ-017 IDLE: start=0 -> remain IDLE.
REQ-018 RUN: each edge SHALL add operand-register bit 0 pair with carry reg, shift result bit into partial-sum reg MSB-side, shift operands right, carry reg := cell carry-out, counter += 1.
REQ-019 RUN: on the edge processing bit WIDTH-1 SHALL write sum, cout and ovf, go DONE.
REQ-020 DONE: done=1 for exactly that cycle; next edge unconditionally -> IDLE.
REQ-021 Latency: start accepted at edge N -> done high during cycle after edge N+WIDTH; busy high cycles after edges N..N+WIDTH-1.
REQ-022 start while in RUN or DONE SHALL be ignored; operand inputs SHALL be don't-care outside the acceptance edge.
REQ-023 cout = carry out of bit WIDTH-1; ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
REQ-024 sum/cout/ovf SHALL change only on the REQ-019 edge or reset; all arithmetic modulo 2^WIDTH.
REQ-025 Back-to-back: start held high SHALL be accepted at the first edge in IDLE after DONE (one idle cycle minimum between ops).

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, counter 0, busy 0, done 0, sum 0, cout 0, ovf 0, all internal regs 0; reset mid-RUN SHALL abort with no result write and no done pulse.

Configuration
REQ-027 Macro SERIAL_ADD_SUB_EN defined: sub=1 at acceptance SHALL invert captured b and force carry reg to 1 (cin ignored), yielding a-b; cout=1 means no borrow.
REQ-028 SERIAL_ADD_SUB_EN undefined: sub port SHALL remain present but be ignored; operation always a+b+cin.

Verification (WIDTH=16)
REQ-029 a=0x0001, b=0x0001, cin=0 -> sum=0x0002, cout=0, ovf=0; done exactly 16 edges after acceptance edge; busy high 16 cycles.
REQ-030 a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0; a=0x7FFF, b=0x0000, cin=1 -> sum=0x8000, cout=0, ovf=1.
REQ-031 SERIAL_ADD_SUB_EN defined, sub=1, a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0; undefined, same stimulus -> sum=0x000C, cout=0.
REQ-032 start pulsed at cycle 5 of RUN with different operands -> ignored; result equals first operation; exactly one done pulse.
REQ-033 rst_n low at cycle 8 of RUN -> busy/done/sum/cout/ovf 0 asynchronously, no done; after release, a new start completes normally.
REQ-034 start held high continuously -> ops repeat with period WIDTH+2 cycles, one done per op, sum stable between done pulses.
